// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode and operand-loader state definitions
package alu_pkg;

  localparam int OP_W   = 4;
  localparam int OP_MAX = 9;

  typedef enum logic [OP_W-1:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    MUL = 4'd2,
    DIV = 4'd3,
    MOD = 4'd4,
    AND = 4'd5,
    OR  = 4'd6,
    XOR = 4'd7,
    SHL = 4'd8,
    SHR = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    READY   = 2'd3
  } ld_state_e;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op, input int op_max);
    return 32'(op) <= op_max;
  endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// rtl/rise_edge_detect.sv - one-cycle pulse on the rising edge of a level input
module rise_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic d_i,
  output logic pulse_o
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b0;
    end else if (clr_i) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign pulse_o = d_i & ~d_q;

endmodule

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - byte-serial loader for ALU operands A, B and opcode
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int BYTE_W   = 8,
  parameter int OP_W_P   = OP_W,
  parameter int OP_MAX_P = OP_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              load,
  input  logic              clear,
  output logic [WIDTH-1:0]  A_out,
  output logic [WIDTH-1:0]  B_out,
  output logic [OP_W_P-1:0] op_out,
  output logic              valid,
  output logic              err,
  output logic [1:0]        stage,
  output logic [1:0]        byte_idx
);

  localparam int         BYTES    = WIDTH / BYTE_W;
  localparam logic [1:0] LAST_IDX = 2'(BYTES - 1);

  ld_state_e         state_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [OP_W_P-1:0] op_q;
  logic              valid_q, err_q;
  logic [1:0]        idx_q, idx_d;
  logic              idx_last;
  logic              wr;
  logic              op_ok;

  rise_edge_detect u_load_edge (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clear),
    .d_i     (load),
    .pulse_o (wr)
  );

  assign idx_last = (idx_q == LAST_IDX);
  assign idx_d    = idx_last ? 2'd0 : idx_q + 2'd1;
  // Upper nibble must be zero too, so a stray switch can't alias to a legal op.
  assign op_ok    = op_is_legal(data_in[OP_W_P-1:0], OP_MAX_P) &&
                    (data_in[BYTE_W-1:OP_W_P] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= 2'd0;
    end else if (clear) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= 2'd0;
    end else begin
      err_q <= 1'b0;
      if (wr) begin
        case (state_q)
          LOAD_A: begin
            a_q[idx_q*BYTE_W +: BYTE_W] <= data_in;
            idx_q <= idx_d;
            if (idx_last) state_q <= LOAD_B;
          end
          LOAD_B: begin
            b_q[idx_q*BYTE_W +: BYTE_W] <= data_in;
            idx_q <= idx_d;
            if (idx_last) state_q <= LOAD_OP;
          end
          LOAD_OP: begin
            if (op_ok) begin
              op_q    <= data_in[OP_W_P-1:0];
              valid_q <= 1'b1;
              state_q <= READY;
            end else begin
              err_q <= 1'b1;
            end
          end
          READY: begin
            // A write here doubles as byte 0 of the next transaction.
            a_q     <= {{(WIDTH-BYTE_W){1'b0}}, data_in};
            b_q     <= '0;
            valid_q <= 1'b0;
            idx_q   <= 2'd1;
            state_q <= LOAD_A;
          end
          default: state_q <= LOAD_A;
        endcase
      end
    end
  end

  assign A_out    = a_q;
  assign B_out    = b_q;
  assign op_out   = op_q;
  assign valid    = valid_q;
  assign err      = err_q;
  assign stage    = state_q;
  assign byte_idx = idx_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - scoreboard bench for alu_operand_loader
module tb_alu_operand_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        load = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] A_out, B_out;
  logic [3:0]  op_out;
  logic        valid, err;
  logic [1:0]  stage, byte_idx;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  localparam int K_VALID = 0;
  localparam int K_ERR   = 1;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t pend;
  logic pend_en = 1'b0;
  logic valid_prev = 1'b0;

  alu_operand_loader dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .load     (load),
    .clear    (clear),
    .A_out    (A_out),
    .B_out    (B_out),
    .op_out   (op_out),
    .valid    (valid),
    .err      (err),
    .stage    (stage),
    .byte_idx (byte_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write: load high for one edge, low for the next.
  task automatic load_byte(input logic [7:0] b);
    data_in = b;
    load = 1'b1;
    tick();
    if (pend_en) begin
      pend.cyc = cyc;
      sb.push_back(pend);
      pend_en = 1'b0;
    end
    load = 1'b0;
    tick();
  endtask

  task automatic expect_evt(input int kind, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op);
    pend.kind = kind;
    pend.a    = a;
    pend.b    = b;
    pend.op   = op;
    pend.cyc  = 0;
    pend_en   = 1'b1;
  endtask

  // Monitor: every valid rise or err cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && ((valid && !valid_prev) || err)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_event: valid=%0b err=%0b with empty scoreboard", valid, err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("evt_kind", {31'd0, err}, (e.kind == K_ERR) ? 32'd1 : 32'd0);
        chk("evt_cycle", cyc, e.cyc);
        chk("evt_op", op_out, e.op);
        if (e.kind == K_VALID) begin
          chk("evt_A", A_out, e.a);
          chk("evt_B", B_out, e.b);
          chk("evt_stage_ready", stage, 32'd3);
        end else begin
          chk("evt_stage_op", stage, 32'd2);
          chk("evt_valid_low", valid, 32'd0);
        end
      end
    end
    valid_prev <= valid;
  end

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_A", A_out, 32'h0);
    chk("rst_B", B_out, 32'h0);
    chk("rst_op", op_out, 32'h0);
    chk("rst_valid", valid, 32'h0);
    chk("rst_err", err, 32'h0);
    chk("rst_stage", stage, 32'h0);
    chk("rst_idx", byte_idx, 32'h0);

    // Full transaction
    load_byte(8'h78); load_byte(8'h56); load_byte(8'h34); load_byte(8'h12);
    chk("A_full", A_out, 32'h12345678);
    chk("stage_B", stage, 32'd1);
    chk("idx_wrap", byte_idx, 32'd0);
    load_byte(8'hEF); load_byte(8'hBE); load_byte(8'hAD); load_byte(8'hDE);
    chk("B_full", B_out, 32'hDEADBEEF);
    chk("stage_OP", stage, 32'd2);
    expect_evt(K_VALID, 32'h12345678, 32'hDEADBEEF, 4'd1);
    load_byte(8'h01);
    chk("stage_ready", stage, 32'd3);
    chk("valid_hold", valid, 32'd1);

    // data_in changes without a write are ignored
    data_in = 8'h5A;
    repeat (3) tick();
    chk("frozen_A", A_out, 32'h12345678);
    chk("frozen_B", B_out, 32'hDEADBEEF);

    // Write from READY starts a new transaction
    load_byte(8'h99);
    chk("restart_valid", valid, 32'd0);
    chk("restart_A", A_out, 32'h00000099);
    chk("restart_B", B_out, 32'h0);
    chk("restart_stage", stage, 32'd0);
    chk("restart_idx", byte_idx, 32'd1);
    chk("restart_op", op_out, 32'd1);

    clear = 1'b1; tick(); clear = 1'b0; tick();
    chk("clear_A", A_out, 32'h0);
    chk("clear_op", op_out, 32'h0);

    // Held load produces exactly one write
    data_in = 8'hAA;
    load = 1'b1;
    repeat (10) tick();
    load = 1'b0;
    tick();
    chk("hold_A", A_out, 32'h000000AA);
    chk("hold_idx", byte_idx, 32'd1);

    load_byte(8'h11); load_byte(8'h22); load_byte(8'h33);
    chk("A_after_hold", A_out, 32'h332211AA);
    load_byte(8'h44); load_byte(8'h55);
    chk("B_partial", B_out, 32'h00005544);
    chk("B_partial_idx", byte_idx, 32'd2);

    // clear beats a coincident load edge
    data_in = 8'h66; load = 1'b1; clear = 1'b1;
    tick();
    load = 1'b0; clear = 1'b0;
    tick();
    chk("clr_ld_A", A_out, 32'h0);
    chk("clr_ld_B", B_out, 32'h0);
    chk("clr_ld_stage", stage, 32'd0);
    chk("clr_ld_idx", byte_idx, 32'd0);

    // Async reset mid-cycle
    load_byte(8'h01); load_byte(8'h02);
    chk("pre_rst_A", A_out, 32'h00000201);
    #2 rst = 1'b1;
    #1;
    chk("async_A", A_out, 32'h0);
    chk("async_stage", stage, 32'd0);
    chk("async_idx", byte_idx, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    tick();

    // Illegal opcodes rejected in LOAD_OP
    load_byte(8'h04); load_byte(8'h03); load_byte(8'h02); load_byte(8'h01);
    load_byte(8'h0D); load_byte(8'h0C); load_byte(8'h0B); load_byte(8'h0A);
    chk("A2", A_out, 32'h01020304);
    chk("B2", B_out, 32'h0A0B0C0D);
    expect_evt(K_ERR, 32'h0, 32'h0, 4'd0);
    load_byte(8'h0C);
    chk("err1_stage", stage, 32'd2);
    chk("err1_op", op_out, 32'd0);
    expect_evt(K_ERR, 32'h0, 32'h0, 4'd0);
    load_byte(8'h15);
    chk("err2_stage", stage, 32'd2);
    chk("err_cleared", err, 32'd0);
    expect_evt(K_VALID, 32'h01020304, 32'h0A0B0C0D, 4'd5);
    load_byte(8'h05);
    chk("op5", op_out, 32'd5);
    chk("op5_valid", valid, 32'd1);

    repeat (4) tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
Upstream stage of the 32-bit ALU. It assembles operands A and B and the 4-bit opcode from a narrow byte-wide input, such as board switches, one byte per load strobe. A 4-state FSM sequences the loads. Once all fields are loaded, the block holds A_out/B_out/op_out stable with valid high, driving the ALU's A, B and op inputs directly.

Parameters:
WIDTH, 32, operand width; must be a multiple of BYTE_W.
BYTE_W, 8, width of data_in.
OP_W, 4, opcode width.
OP_MAX, 9, highest legal opcode (0=add … 9=shift right).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
data_in  input  BYTE_W  byte to load.
load  input  1  level load request, already debounced and synchronised; the block edge-detects it.
clear  input  1  synchronous abort; returns the block to the start.
A_out  output  WIDTH  assembled operand A, to ALU A.
B_out  output  WIDTH  assembled operand B, to ALU B.
op_out  output  OP_W  assembled opcode, to ALU op.
valid  output  1  A_out, B_out and op_out are complete and stable.
err  output  1  one-cycle pulse: an illegal opcode was rejected.
stage  output  2  current FSM state encoding.
byte_idx  output  2  next byte slot within the current operand.

Behaviour:
- Reset (async, rst=1): A_out=0, B_out=0, op_out=0, valid=0, err=0, state=LOAD_A, byte_idx=0, load_q=0.
- Load detection:
  - load_q registers load every cycle.
  - A write occurs at the rising edge where load=1 and load_q=0.
  - Holding load high for N cycles produces exactly one write.
- BYTES = WIDTH/BYTE_W (4 by default).
  - Byte i is written to bits [BYTE_W*i+BYTE_W-1 : BYTE_W*i], LSB byte first.
  - Other bits are untouched.
- LOAD_A (stage=0):
  - Each write fills A_out byte slot byte_idx.
  - byte_idx increments.
  - After the write with byte_idx=BYTES-1: byte_idx wraps to 0, go to LOAD_B.
- LOAD_B (stage=1): same as LOAD_A, filling B_out; after the last byte, go to LOAD_OP.
- LOAD_OP (stage=2):
  - A write with data_in[OP_W-1:0] ≤ OP_MAX and data_in[BYTE_W-1:OP_W]=0 sets op_out and goes to READY.
  - Otherwise op_out is unchanged, err=1 for exactly the next cycle, and the state stays LOAD_OP.
- READY (stage=3):
  - valid=1, registered, asserted the cycle after the op write.
  - Outputs are frozen.
  - A write starts a new transaction: A_out slot 0 takes data_in, all other A_out bits are cleared, B_out is cleared, valid drops after the same edge, byte_idx=1, state=LOAD_A.
- valid is 0 in every state except READY.
- The ALU is combinational, so a result is available the same cycle valid rises. No further handshake.
- clear=1 at a rising edge: same effect as reset, but synchronous. clear takes priority over a coincident load edge; that byte is discarded.
- rst asserted mid-transaction: immediate return to reset values, partial operand discarded.
- data_in is sampled only at write edges; changes at other times have no effect.
- Outputs change only at rising clock edges, except on async reset.

Decomposition:
- Package alu_pkg holds:
  - op_e enum: ADD=0, SUB=1, MUL=2, DIV=3, MOD=4, AND=5, OR=6, XOR=7, SHL=8, SHR=9; shared with the ALU controller.
  - OP_MAX constant.
  - ld_state_e enum: LOAD_A=0, LOAD_B=1, LOAD_OP=2, READY=3.
- One sub-module, rise_edge_detect: a 1-bit register plus AND, producing the write pulse from load.
- The FSM and byte-slot write logic stay in alu_operand_loader.

Test Plan:
- Reset with rst=1 for 2 cycles, then release → all outputs 0, stage=0, byte_idx=0, valid=0.
- Load bytes 78,56,34,12, then EF,BE,AD,DE, then 01 → A_out=0x12345678, B_out=0xDEADBEEF, op_out=1, valid=1 one cycle after the op write, stage=3.
- In LOAD_OP, load 0x0C, then 0x15, then 0x05:
  - 0x0C → err pulses 1 cycle, op_out stays 0, stage stays 2.
  - 0x15 → same response.
  - 0x05 → op_out=5, valid=1.
- Hold load high for 10 cycles with data_in=AA in LOAD_A → only slot 0 written (A_out=0x000000AA), byte_idx=1.
- After 2 bytes of B, assert clear together with a load edge → A_out=B_out=0, stage=0, byte_idx=0, byte discarded. Repeat with async rst asserted mid-cycle → outputs clear before the next clock edge.
- From READY with A=0x12345678, B=0xDEADBEEF, load 0x99 → valid=0, A_out=0x00000099, B_out=0, stage=0, byte_idx=1.
